// File: rtl/clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clk_switch_ctrl
//
// Purpose:
//   Drives the select input of the glitch-free clock switch. It accepts
//   software switch requests through a valid/ready handshake, synchronizes and
//   debounces the per-source clock-fail flags into sticky status bits, and
//   holds a settle window (busy) after every select change.
//
// Optional feature:
//   CLK_SW_AUTO_FAILOVER_EN  - when defined, a failure of the selected source
//                              switches automatically to the lowest-index
//                              healthy source. If no source is healthy, the
//                              controller parks in ALLFAIL until one recovers.
//                              When undefined, failures are only reported.
//
// Ports:
//   clk        always-on reference clock
//   rst_n      asynchronous active-low reset
//   req_vld    switch request valid
//   req_sel    requested source index
//   req_rdy    request accepted when req_vld && req_rdy
//   req_err    one-cycle pulse: accepted request rejected (bad index / failed)
//   clk_fail   asynchronous per-source fail flags from the clock monitors
//   fail_clr   per-source sticky-fail clear (honoured only once the fail is gone)
//   sel        registered select to the switch
//   busy       settle window active
//   sw_done    one-cycle switch-complete pulse
//   fail_stat  sticky debounced fail status
//   fail_irq   one-cycle pulse when any fail_stat bit rises
//   all_fail   every source is failed
// -----------------------------------------------------------------------------
module clk_switch_ctrl #(
  parameter int CLK_NUM    = 4,
  parameter int SEL_W      = $clog2(CLK_NUM),
  parameter int DEF_SEL    = 0,
  parameter int SETTLE_CYC = 16,
  parameter int FAIL_DEB   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_rdy,
  output logic               req_err,
  input  logic [CLK_NUM-1:0] clk_fail,
  input  logic [CLK_NUM-1:0] fail_clr,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               sw_done,
  output logic [CLK_NUM-1:0] fail_stat,
  output logic               fail_irq,
  output logic               all_fail
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ALLFAIL = 2'd2
  } state_t;

  // The counter holds the remaining cycles after the current one, so loading
  // SETTLE_CYC-1 gives exactly SETTLE_CYC cycles of busy.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [CLK_NUM-1:0] fail_stat_reg, fail_stat_next;
  logic               busy_reg, busy_next;
  logic               req_rdy_reg, req_rdy_next;
  logic               req_err_reg, req_err_next;
  logic               sw_done_reg, sw_done_next;
  logic               fail_irq_reg, fail_irq_next;
  logic               all_fail_reg, all_fail_next;

  // ---------------------------------------------------------------------------
  // Per-source fail path: 2-FF synchronizer, saturating debounce counter and
  // sticky status. The status sets on the same edge the counter reaches
  // FAIL_DEB. A clear only takes effect while the synced fail is low, so set
  // and clear can never collide.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CLK_NUM; gi++) begin : g_src
      logic       sync1_reg;
      logic       sync2_reg;
      logic [3:0] deb_cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= clk_fail[gi];
          sync2_reg <= sync1_reg;
          if (!sync2_reg)
            deb_cnt_reg <= '0;
          else if (deb_cnt_reg != 4'(FAIL_DEB))
            deb_cnt_reg <= deb_cnt_reg + 4'd1;
        end
      end

      assign fail_stat_next[gi] = (sync2_reg && (deb_cnt_reg == 4'(FAIL_DEB - 1))) ||
                                  (fail_stat_reg[gi] && !(fail_clr[gi] && !sync2_reg));
    end
  endgenerate

`ifdef CLK_SW_AUTO_FAILOVER_EN
  logic [SEL_W-1:0] lowest_healthy;
  logic             any_healthy;

  // Scan from the top down so the lowest healthy index wins.
  always_comb begin
    lowest_healthy = '0;
    for (int i = CLK_NUM - 1; i >= 0; i--) begin
      if (!fail_stat_reg[i]) lowest_healthy = SEL_W'(i);
    end
  end
  assign any_healthy = ~&fail_stat_reg;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer next-state and registered-output logic
  // ---------------------------------------------------------------------------
  logic accept;
  logic req_in_range;

  assign accept       = req_vld && req_rdy_reg;
  assign req_in_range = (int'(req_sel) < CLK_NUM);

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    cnt_next     = cnt_reg;
    req_err_next = 1'b0;
    sw_done_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
`ifdef CLK_SW_AUTO_FAILOVER_EN
        // Failover pre-empts any request presented in the same cycle.
        if (fail_stat_reg[sel_reg]) begin
          if (any_healthy) begin
            sel_next   = lowest_healthy;
            cnt_next   = SETTLE_LOAD;
            state_next = ST_SETTLE;
          end else begin
            state_next = ST_ALLFAIL;
          end
        end else
`endif
        if (accept) begin
          if (!req_in_range || fail_stat_reg[req_sel]) begin
            req_err_next = 1'b1;
          end else if (req_sel == sel_reg) begin
            sw_done_next = 1'b1;
          end else begin
            sel_next   = req_sel;
            cnt_next   = SETTLE_LOAD;
            state_next = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        // Runs to completion even if the new source fails meanwhile; that
        // failure is picked up on return to IDLE.
        if (cnt_reg == 8'd0) begin
          state_next   = ST_IDLE;
          sw_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end

      ST_ALLFAIL: begin
`ifdef CLK_SW_AUTO_FAILOVER_EN
        if (any_healthy) begin
          sel_next   = lowest_healthy;
          cnt_next   = SETTLE_LOAD;
          state_next = ST_SETTLE;
        end
`endif
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so each one changes on
  // the same edge as the state it describes.
  always_comb begin
    busy_next     = (state_next == ST_SETTLE);
    fail_irq_next = |(fail_stat_next & ~fail_stat_reg);
`ifdef CLK_SW_AUTO_FAILOVER_EN
    all_fail_next = (state_next == ST_ALLFAIL);
    // Hold off requests in a cycle where a failover is about to be taken.
    req_rdy_next  = (state_next == ST_IDLE) && !fail_stat_next[sel_next];
`else
    all_fail_next = &fail_stat_next;
    req_rdy_next  = (state_next == ST_IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= SEL_W'(DEF_SEL);
      cnt_reg       <= '0;
      fail_stat_reg <= '0;
      busy_reg      <= 1'b0;
      req_rdy_reg   <= 1'b1;
      req_err_reg   <= 1'b0;
      sw_done_reg   <= 1'b0;
      fail_irq_reg  <= 1'b0;
      all_fail_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      cnt_reg       <= cnt_next;
      fail_stat_reg <= fail_stat_next;
      busy_reg      <= busy_next;
      req_rdy_reg   <= req_rdy_next;
      req_err_reg   <= req_err_next;
      sw_done_reg   <= sw_done_next;
      fail_irq_reg  <= fail_irq_next;
      all_fail_reg  <= all_fail_next;
    end
  end

  assign sel       = sel_reg;
  assign busy      = busy_reg;
  assign req_rdy   = req_rdy_reg;
  assign req_err   = req_err_reg;
  assign sw_done   = sw_done_reg;
  assign fail_stat = fail_stat_reg;
  assign fail_irq  = fail_irq_reg;
  assign all_fail  = all_fail_reg;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_switch_ctrl
//
// Directed testbench for clk_switch_ctrl with default parameters
// (CLK_NUM=4, DEF_SEL=0, SETTLE_CYC=16, FAIL_DEB=4). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_clk_switch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_vld;
  logic [1:0] req_sel;
  logic       req_rdy;
  logic       req_err;
  logic [3:0] clk_fail;
  logic [3:0] fail_clr;
  logic [1:0] sel;
  logic       busy;
  logic       sw_done;
  logic [3:0] fail_stat;
  logic       fail_irq;
  logic       all_fail;

  int tests_run    = 0;
  int tests_failed = 0;

  clk_switch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_sel   (req_sel),
    .req_rdy   (req_rdy),
    .req_err   (req_err),
    .clk_fail  (clk_fail),
    .fail_clr  (fail_clr),
    .sel       (sel),
    .busy      (busy),
    .sw_done   (sw_done),
    .fail_stat (fail_stat),
    .fail_irq  (fail_irq),
    .all_fail  (all_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 1'b0; req_sel = 2'd0; clk_fail = 4'd0; fail_clr = 4'd0;
    tick(3);
    tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if ({req_err, sw_done, fail_irq, all_fail} !== 4'b0000) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 0000", {req_err, sw_done, fail_irq, all_fail}); end
    tests_run++; if (fail_stat !== 4'b0000) begin tests_failed++; $display("FAIL reset_fail_stat: got %b expected 0000", fail_stat); end
    rst_n = 1'b1;
    tick(1);
    tests_run++; if (req_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_req_rdy: got %b expected 1", req_rdy); end
    $display("[TB] reset released sel=%0d req_rdy=%b", sel, req_rdy);
  endtask

  task automatic test_basic_switch();
    req_vld = 1'b1; req_sel = 2'd2;          // accepted at this cycle (N)
    tick(1);                                 // N+1
    req_vld = 1'b0;
    tests_run++; if (sel !== 2'd2) begin tests_failed++; $display("FAIL basic_sel: got %0d expected 2", sel); end
    for (int k = 1; k <= 16; k++) begin
      tests_run++;
      if (busy !== 1'b1 || req_rdy !== 1'b0 || sw_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_settle_cycle%0d: got busy=%b rdy=%b done=%b expected busy=1 rdy=0 done=0", k, busy, req_rdy, sw_done);
      end
      tick(1);
    end
    // Now at N+17
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    tests_run++; if (sw_done !== 1'b1) begin tests_failed++; $display("FAIL basic_sw_done: got %b expected 1", sw_done); end
    tests_run++; if (req_rdy !== 1'b1) begin tests_failed++; $display("FAIL basic_req_rdy_end: got %b expected 1", req_rdy); end
    tick(1);
    tests_run++; if (sw_done !== 1'b0) begin tests_failed++; $display("FAIL basic_sw_done_pulse: got %b expected 0", sw_done); end
    $display("[TB] switch to 2 complete sel=%0d", sel);
  endtask

  task automatic test_same_sel();
    req_vld = 1'b1; req_sel = 2'd2;
    tick(1);
    req_vld = 1'b0;
    tests_run++; if (sw_done !== 1'b1) begin tests_failed++; $display("FAIL same_sw_done: got %b expected 1", sw_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL same_busy: got %b expected 0", busy); end
    tests_run++; if (sel !== 2'd2 || req_rdy !== 1'b1) begin tests_failed++; $display("FAIL same_sel_rdy: got sel=%0d rdy=%b expected sel=2 rdy=1", sel, req_rdy); end
    tick(1);
    tests_run++; if (sw_done !== 1'b0) begin tests_failed++; $display("FAIL same_sw_done_pulse: got %b expected 0", sw_done); end
    $display("[TB] same-source request sel=%0d", sel);
  endtask

  task automatic test_debounce();
    int irq_cnt;
    // 3-cycle glitch: synced value is high for only 3 cycles
    clk_fail[0] = 1'b1;
    tick(3);
    clk_fail[0] = 1'b0;
    irq_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (fail_irq === 1'b1) irq_cnt++;
    end
    tests_run++; if (fail_stat !== 4'b0000) begin tests_failed++; $display("FAIL deb_glitch_stat: got %b expected 0000", fail_stat); end
    tests_run++; if (irq_cnt !== 0) begin tests_failed++; $display("FAIL deb_glitch_irq: got %0d pulses expected 0", irq_cnt); end
    $display("[TB] 3-cycle glitch fail_stat=%b", fail_stat);
    // 6-cycle high: 2 sync cycles + 4 debounce cycles
    clk_fail[0] = 1'b1;
    tick(5);
    tests_run++; if (fail_stat !== 4'b0000) begin tests_failed++; $display("FAIL deb_early_stat: got %b expected 0000", fail_stat); end
    tick(1);
    tests_run++; if (fail_stat !== 4'b0001) begin tests_failed++; $display("FAIL deb_set_stat: got %b expected 0001", fail_stat); end
    tests_run++; if (fail_irq !== 1'b1) begin tests_failed++; $display("FAIL deb_set_irq: got %b expected 1", fail_irq); end
    clk_fail[0] = 1'b0;
    irq_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (fail_irq === 1'b1) irq_cnt++;
    end
    tests_run++; if (irq_cnt !== 0) begin tests_failed++; $display("FAIL deb_single_irq: got %0d extra pulses expected 0", irq_cnt); end
    tests_run++; if (fail_stat !== 4'b0001) begin tests_failed++; $display("FAIL deb_sticky: got %b expected 0001", fail_stat); end
    tests_run++; if (sel !== 2'd2) begin tests_failed++; $display("FAIL deb_sel: got %0d expected 2", sel); end
    fail_clr[0] = 1'b1;
    tick(1);
    fail_clr[0] = 1'b0;
    tests_run++; if (fail_stat !== 4'b0000) begin tests_failed++; $display("FAIL deb_clear: got %b expected 0000", fail_stat); end
    $display("[TB] 6-cycle fail then clear fail_stat=%b", fail_stat);
  endtask

  task automatic test_reject();
    clk_fail[1] = 1'b1;
    tick(6);
    tests_run++; if (fail_stat !== 4'b0010) begin tests_failed++; $display("FAIL rej_fail_stat: got %b expected 0010", fail_stat); end
    req_vld = 1'b1; req_sel = 2'd1;
    tick(1);
    req_vld = 1'b0;
    tests_run++; if (req_err !== 1'b1) begin tests_failed++; $display("FAIL rej_req_err: got %b expected 1", req_err); end
    tests_run++; if (sel !== 2'd2 || busy !== 1'b0 || sw_done !== 1'b0) begin tests_failed++; $display("FAIL rej_no_switch: got sel=%0d busy=%b done=%b expected sel=2 busy=0 done=0", sel, busy, sw_done); end
    tick(1);
    tests_run++; if (req_err !== 1'b0) begin tests_failed++; $display("FAIL rej_err_pulse: got %b expected 0", req_err); end
    $display("[TB] request to failed source 1 rejected sel=%0d", sel);
    // Clear while fail still present is ignored
    fail_clr[1] = 1'b1;
    tick(1);
    fail_clr[1] = 1'b0;
    tests_run++; if (fail_stat !== 4'b0010) begin tests_failed++; $display("FAIL rej_clr_ignored: got %b expected 0010", fail_stat); end
    clk_fail[1] = 1'b0;
    tick(3);
    fail_clr[1] = 1'b1;
    tick(1);
    fail_clr[1] = 1'b0;
    tests_run++; if (fail_stat !== 4'b0000) begin tests_failed++; $display("FAIL rej_clr: got %b expected 0000", fail_stat); end
  endtask

`ifdef CLK_SW_AUTO_FAILOVER_EN
  task automatic test_failover();
    do_reset();
    clk_fail = 4'b0011;
    tick(6);
    tests_run++; if (fail_stat !== 4'b0011 || fail_irq !== 1'b1) begin tests_failed++; $display("FAIL fo_stat_irq: got stat=%b irq=%b expected stat=0011 irq=1", fail_stat, fail_irq); end
    tests_run++; if (req_rdy !== 1'b0 || sel !== 2'd0) begin tests_failed++; $display("FAIL fo_pending: got rdy=%b sel=%0d expected rdy=0 sel=0", req_rdy, sel); end
    req_vld = 1'b1; req_sel = 2'd3;          // competes with the failover
    tick(1);
    req_vld = 1'b0;
    tests_run++; if (sel !== 2'd2 || busy !== 1'b1) begin tests_failed++; $display("FAIL fo_sel: got sel=%0d busy=%b expected sel=2 busy=1", sel, busy); end
    tests_run++; if (fail_irq !== 1'b0) begin tests_failed++; $display("FAIL fo_irq_pulse: got %b expected 0", fail_irq); end
    for (int k = 1; k <= 16; k++) begin
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL fo_busy_cycle%0d: got %b expected 1", k, busy); end
      tick(1);
    end
    tests_run++; if (sw_done !== 1'b1 || busy !== 1'b0 || sel !== 2'd2) begin tests_failed++; $display("FAIL fo_done: got done=%b busy=%b sel=%0d expected done=1 busy=0 sel=2", sw_done, busy, sel); end
    $display("[TB] failover 0 -> %0d complete", sel);
  endtask

  task automatic test_all_fail();
    clk_fail = 4'b1111;
    tick(6);
    tests_run++; if (fail_stat !== 4'b1111 || fail_irq !== 1'b1) begin tests_failed++; $display("FAIL af_stat: got stat=%b irq=%b expected stat=1111 irq=1", fail_stat, fail_irq); end
    tick(1);
    tests_run++; if (all_fail !== 1'b1 || sel !== 2'd2) begin tests_failed++; $display("FAIL af_enter: got all_fail=%b sel=%0d expected all_fail=1 sel=2", all_fail, sel); end
    tick(5);
    tests_run++; if (all_fail !== 1'b1 || sel !== 2'd2 || req_rdy !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL af_hold: got all_fail=%b sel=%0d rdy=%b busy=%b expected 1/2/0/0", all_fail, sel, req_rdy, busy); end
    clk_fail[3] = 1'b0;
    tick(3);
    fail_clr[3] = 1'b1;
    tick(1);
    fail_clr[3] = 1'b0;
    tests_run++; if (fail_stat !== 4'b0111 || all_fail !== 1'b1) begin tests_failed++; $display("FAIL af_clr: got stat=%b all_fail=%b expected stat=0111 all_fail=1", fail_stat, all_fail); end
    tick(1);
    tests_run++; if (sel !== 2'd3 || all_fail !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL af_recover: got sel=%0d all_fail=%b busy=%b expected sel=3 all_fail=0 busy=1", sel, all_fail, busy); end
    tick(16);
    tests_run++; if (sw_done !== 1'b1) begin tests_failed++; $display("FAIL af_done: got %b expected 1", sw_done); end
    $display("[TB] recovered from all-fail sel=%0d", sel);
    clk_fail = 4'b0000;
  endtask
`else
  task automatic test_no_failover();
    int busy_seen;
    clk_fail[2] = 1'b1;                      // current source fails
    tick(6);
    tests_run++; if (fail_stat !== 4'b0100 || fail_irq !== 1'b1) begin tests_failed++; $display("FAIL nofo_stat_irq: got stat=%b irq=%b expected stat=0100 irq=1", fail_stat, fail_irq); end
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (busy === 1'b1) busy_seen++;
    end
    tests_run++; if (sel !== 2'd2 || busy_seen !== 0) begin tests_failed++; $display("FAIL nofo_hold: got sel=%0d busy_cycles=%0d expected sel=2 busy_cycles=0", sel, busy_seen); end
    tests_run++; if (req_rdy !== 1'b1 || all_fail !== 1'b0) begin tests_failed++; $display("FAIL nofo_rdy: got rdy=%b all_fail=%b expected rdy=1 all_fail=0", req_rdy, all_fail); end
    req_vld = 1'b1; req_sel = 2'd3;
    tick(1);
    req_vld = 1'b0;
    tests_run++; if (sel !== 2'd3 || busy !== 1'b1) begin tests_failed++; $display("FAIL nofo_req: got sel=%0d busy=%b expected sel=3 busy=1", sel, busy); end
    $display("[TB] no autonomous switch, manual request to 3 accepted");
    clk_fail = 4'b0000;
  endtask
`endif

  task automatic test_reset_mid_settle();
    clk_fail = 4'b0000;
    do_reset();
    req_vld = 1'b1; req_sel = 2'd3;
    tick(1);
    req_vld = 1'b0;
    tests_run++; if (sel !== 2'd3 || busy !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_start: got sel=%0d busy=%b expected sel=3 busy=1", sel, busy); end
    tick(4);
    rst_n = 1'b0;
    #1;
    tests_run++; if (sel !== 2'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_abort: got sel=%0d busy=%b expected sel=0 busy=0", sel, busy); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    tests_run++; if (req_rdy !== 1'b1 || sel !== 2'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_after: got rdy=%b sel=%0d busy=%b expected rdy=1 sel=0 busy=0", req_rdy, sel, busy); end
    $display("[TB] reset mid-settle sel=%0d busy=%b", sel, busy);
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_same_sel();
    test_debounce();
    test_reject();
`ifdef CLK_SW_AUTO_FAILOVER_EN
    test_failover();
    test_all_fail();
`else
    test_no_failover();
`endif
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
